// File: rtl/IO_UnitTypes.sv
// Shared types and defaults for the IO unit serial transmit path.
package IO_UnitTypes;

  localparam int SERIAL_TX_FIFO_DEPTH  = 16;
  localparam int SERIAL_TX_CLK_PER_BIT = 542;  // 62.5 MHz / 115200 baud

  localparam int SERIAL_TX_QUEUE_INDEX_WIDTH = $clog2(SERIAL_TX_FIFO_DEPTH);

  typedef logic [SERIAL_TX_QUEUE_INDEX_WIDTH-1:0] SerialTxQueuePath;
  typedef logic [7:0] SerialDataPath;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef RSD_SERIAL_TX_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } SerialTxState;

endpackage

// File: rtl/serial_tx_queue.sv
// Circular byte FIFO: write visible one cycle after push, head read combinationally.
// full is registered; writes while full and pops while empty are ignored.
module serial_tx_queue
  import IO_UnitTypes::*;
#(
  parameter int FIFO_DEPTH = SERIAL_TX_FIFO_DEPTH
)(
  input  logic       clk,
  input  logic       negResetIn,
  input  logic       push,
  input  logic [7:0] pushData,
  input  logic       pop,
  output logic [7:0] headData,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  logic [7:0]       storage [FIFO_DEPTH];
  logic [PTR_W-1:0] headPtr;
  logic [PTR_W-1:0] tailPtr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] countNext;
  logic             pushOk;
  logic             popOk;

  assign pushOk   = push && !full;
  assign popOk    = pop && !empty;
  assign empty    = (count == '0);
  assign headData = storage[headPtr];

  always_comb begin
    countNext = count;
    case ({pushOk, popOk})
      2'b10:   countNext = count + 1'b1;
      2'b01:   countNext = count - 1'b1;
      default: countNext = count;
    endcase
  end

  // Depth is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge negResetIn) begin
    if (!negResetIn) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
      full    <= 1'b0;
    end else begin
      if (pushOk) tailPtr <= tailPtr + 1'b1;
      if (popOk)  headPtr <= headPtr + 1'b1;
      count <= countNext;
      full  <= (countNext == DEPTH_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (pushOk) storage[tailPtr] <= pushData;
  end

endmodule

// File: rtl/serial_tx_buffer.sv
// Queued UART transmitter: a write to an idle, empty buffer drives the start bit two cycles later.
// Writes while serialFull are dropped and latch overflow; RSD_SERIAL_TX_PARITY_EN adds an even parity bit.
module serial_tx_buffer
  import IO_UnitTypes::*;
#(
  parameter int FIFO_DEPTH  = SERIAL_TX_FIFO_DEPTH,
  parameter int CLK_PER_BIT = SERIAL_TX_CLK_PER_BIT
)(
  input  logic       clk,
  input  logic       negResetIn,
  input  logic       serialWE,
  input  logic [7:0] serialWriteData,
  output logic       serialFull,
  output logic       txBusy,
  output logic       overflow,
  output logic       txd
);

  localparam int BAUD_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_PER_BIT - 1);

  SerialTxState      state;
  logic [BAUD_W-1:0] baudCnt;
  logic [2:0]        bitIdx;
  logic [7:0]        shiftReg;
  logic [7:0]        qHead;
  logic              qEmpty;
  logic              qFull;
  logic              qPush;
  logic              qPop;
  logic              baudLast;
`ifdef RSD_SERIAL_TX_PARITY_EN
  logic              parityBit;
`endif

  serial_tx_queue #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) queue (
    .clk        (clk),
    .negResetIn (negResetIn),
    .push       (qPush),
    .pushData   (serialWriteData),
    .pop        (qPop),
    .headData   (qHead),
    .full       (qFull),
    .empty      (qEmpty)
  );

  assign baudLast   = (baudCnt == BAUD_LAST);
  assign qPush      = serialWE && !qFull;
  // A frame is fetched either from idle or at the very end of a stop bit.
  assign qPop       = !qEmpty && ((state == TX_IDLE) || ((state == TX_STOP) && baudLast));
  assign serialFull = qFull;
  assign txBusy     = (state != TX_IDLE) || !qEmpty;

  always_ff @(posedge clk or negedge negResetIn) begin
    if (!negResetIn) begin
      overflow <= 1'b0;
    end else if (serialWE && qFull) begin
      overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge negResetIn) begin
    if (!negResetIn) begin
      state    <= TX_IDLE;
      txd      <= 1'b1;
      baudCnt  <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
`ifdef RSD_SERIAL_TX_PARITY_EN
      parityBit <= 1'b0;
`endif
    end else begin
      case (state)
        TX_IDLE: begin
          txd <= 1'b1;
          if (!qEmpty) begin
            shiftReg <= qHead;
`ifdef RSD_SERIAL_TX_PARITY_EN
            parityBit <= ^qHead;
`endif
            baudCnt  <= '0;
            state    <= TX_START;
            txd      <= 1'b0;
          end
        end

        TX_START: begin
          if (baudLast) begin
            baudCnt <= '0;
            bitIdx  <= '0;
            state   <= TX_DATA;
            txd     <= shiftReg[0];
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end

        // txd is registered, so each bit boundary loads the value of the next bit.
        TX_DATA: begin
          if (baudLast) begin
            baudCnt <= '0;
            if (bitIdx == 3'd7) begin
`ifdef RSD_SERIAL_TX_PARITY_EN
              state <= TX_PARITY;
              txd   <= parityBit;
`else
              state <= TX_STOP;
              txd   <= 1'b1;
`endif
            end else begin
              shiftReg <= {1'b0, shiftReg[7:1]};
              bitIdx   <= bitIdx + 3'd1;
              txd      <= shiftReg[1];
            end
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end

`ifdef RSD_SERIAL_TX_PARITY_EN
        TX_PARITY: begin
          if (baudLast) begin
            baudCnt <= '0;
            state   <= TX_STOP;
            txd     <= 1'b1;
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
`endif

        TX_STOP: begin
          if (baudLast) begin
            baudCnt <= '0;
            if (!qEmpty) begin
              shiftReg <= qHead;
`ifdef RSD_SERIAL_TX_PARITY_EN
              parityBit <= ^qHead;
`endif
              state    <= TX_START;
              txd      <= 1'b0;
            end else begin
              state <= TX_IDLE;
              txd   <= 1'b1;
            end
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end

        default: begin
          state   <= TX_IDLE;
          txd     <= 1'b1;
          baudCnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_buffer.sv
// Randomised scoreboard bench for serial_tx_buffer with CLK_PER_BIT=4, FIFO_DEPTH=4.
module tb_serial_tx_buffer;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef RSD_SERIAL_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic       clk = 1'b0;
  logic       negResetIn = 1'b1;
  logic       serialWE = 1'b0;
  logic [7:0] serialWriteData = 8'h00;
  logic       serialFull;
  logic       txBusy;
  logic       overflow;
  logic       txd;

  serial_tx_buffer #(
    .FIFO_DEPTH  (DEPTH),
    .CLK_PER_BIT (CPB)
  ) dut (
    .clk             (clk),
    .negResetIn      (negResetIn),
    .serialWE        (serialWE),
    .serialWriteData (serialWriteData),
    .serialFull      (serialFull),
    .txBusy          (txBusy),
    .overflow        (overflow),
    .txd             (txd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [7:0] b;
    int         start;
  } exp_t;

  // Reference model: bytes waiting in the queue, time of the last frame fetch, sticky overflow.
  logic [7:0] mq[$];
  exp_t       sb[$];
  int         lastPop = -1000;
  bit         ovfModel = 1'b0;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  // Expected line waveform, one entry per clock: start, 8 data bits LSB first, optional parity, stop.
  function automatic logic [63:0] frameOf(input logic [7:0] b);
    logic [63:0] f;
    int k;
    f = '1;
    for (int i = 0; i < FRAME; i++) begin
      k = i / CPB;
      if (k == 0)                      f[i] = 1'b0;
      else if (k <= 8)                 f[i] = b[k-1];
      else if (k == 9 && NBITS == 11)  f[i] = ^b;
      else                             f[i] = 1'b1;
    end
    return f;
  endfunction

  task automatic step(input logic we, input logic [7:0] d);
    bit fullM;
    bit busyM;
    @(negedge clk);
    fullM = (mq.size() == DEPTH);
    busyM = (mq.size() != 0) || (cyc >= lastPop + 1 && cyc <= lastPop + FRAME);
    check("serialFull", serialFull, fullM);
    check("txBusy", txBusy, busyM);
    check("overflow", overflow, ovfModel);
    serialWE = we;
    serialWriteData = d;
    if (mq.size() != 0 && cyc >= lastPop + FRAME) begin
      sb.push_back('{mq[0], cyc + 1});
      void'(mq.pop_front());
      lastPop = cyc;
    end
    if (we) begin
      if (fullM) ovfModel = 1'b1;
      else mq.push_back(d);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((mq.size() != 0 || sb.size() != 0) && guard < 2000) begin
      step(1'b0, 8'h00);
      guard++;
    end
    if (guard >= 2000) begin
      checks++;
      $display("FAIL drain: %0d frames still expected after %0d cycles", sb.size() + mq.size(), guard);
    end
    idle(4);
  endtask

  task automatic resetModel();
    mq.delete();
    sb.delete();
    lastPop = -1000;
    ovfModel = 1'b0;
  endtask

  // Line monitor: captures each frame cycle by cycle and compares against the scoreboard.
  initial begin
    bit          inFrame;
    int          n;
    int          startC;
    logic [63:0] samp;
    exp_t        e;
    inFrame = 1'b0;
    n = 0;
    startC = 0;
    samp = '1;
    forever begin
      @(negedge clk);
      if (!negResetIn) begin
        inFrame = 1'b0;
      end else begin
        if (!inFrame && txd == 1'b0) begin
          inFrame = 1'b1;
          n = 0;
          startC = cyc;
          samp = '1;
        end
        if (inFrame) begin
          samp[n] = txd;
          n++;
          if (n == FRAME) begin
            inFrame = 1'b0;
            if (sb.size() == 0) begin
              checks++;
              $display("FAIL frame: unexpected frame at cycle %0d, line %0h, expected none", startC, samp);
            end else begin
              e = sb.pop_front();
              check("frameBits", samp, frameOf(e.b));
              check("frameStart", 64'(startC), 64'(e.start));
            end
          end
        end
      end
    end
  end

  initial begin
    int guard;
    #1 negResetIn = 1'b0;
    #1;
    check("resetTxd", txd, 1'b1);
    check("resetFull", serialFull, 1'b0);
    check("resetBusy", txBusy, 1'b0);
    check("resetOverflow", overflow, 1'b0);
    @(posedge clk) #2 negResetIn = 1'b1;

    // Single byte, then a back-to-back pair, then the two parity patterns.
    step(1'b1, 8'h55);
    idle(50);
    step(1'b1, 8'h41);
    step(1'b1, 8'h42);
    drain();
    step(1'b1, 8'h07);
    step(1'b1, 8'h03);
    drain();

    // Stream ten bytes through the queue without ever filling it.
    for (int i = 0; i < 10; i++) begin
      guard = 0;
      while (mq.size() >= DEPTH - 1 && guard < 500) begin
        step(1'b0, 8'h00);
        guard++;
      end
      step(1'b1, 8'(i));
      idle($urandom_range(0, 3));
    end
    drain();

    // Six consecutive writes: the sixth finds the queue full and is dropped.
    for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom));
    drain();

    // Fill the queue again and reset while a zero byte is mid-data.
    step(1'b1, 8'h00);
    for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom));
    idle(8);
    @(posedge clk) #2 negResetIn = 1'b0;
    #1;
    check("midResetTxd", txd, 1'b1);
    check("midResetFull", serialFull, 1'b0);
    check("midResetOverflow", overflow, 1'b0);
    check("midResetBusy", txBusy, 1'b0);
    resetModel();
    @(posedge clk) #2 negResetIn = 1'b1;
    step(1'b1, 8'hA5);
    drain();

    // Random traffic, including bursts that overflow.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 7) == 0, 8'($urandom));
    end
    drain();

    check("leftoverFrames", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
